// File: rtl/subtrator_pkg.sv
// Shared definitions for the subtractor datapath.
//   LAT_MAX   : deepest legal output pipeline
//   fs_diff   : 1-bit full-subtractor difference  (a - b - bin)
//   fs_borrow : 1-bit full-subtractor borrow-out
package subtrator_pkg;

    localparam int LAT_MAX = 4;

    function automatic logic fs_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    // Borrow when b exceeds a outright, or when they tie and a borrow comes in.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/subtrator_completo_fs_pipe.sv
// fs_pipe: W-bit wide, DEPTH-deep shift register with synchronous reset to 0.
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous reset, active-high; clears every stage
//   d    in  W   value captured into stage 0
//   q    out W   last stage (d delayed by DEPTH edges, first edge included)
module fs_pipe #(
    parameter int W     = 2,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH-1:0][W-1:0] stg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/subtrator_completo.sv
// subtrator_completo: 1-bit full subtractor (a - b - cin) with LATENCY registered
// output stages and an LSB-first bit-serial chaining mode.
// Parameters:
//   LATENCY  output register stages, 1..LAT_MAX (other values fail elaboration)
// Ports:
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous reset, active-high
//   a       in   1  minuend bit
//   b       in   1  subtrahend bit
//   cin     in   1  borrow-in, used when serial=0
//   serial  in   1  1 = take borrow-in from the internal borrow register
//   s       out  1  difference bit
//   cout    out  1  borrow-out bit
//   zero    out  1  word-so-far-is-zero flag (only with COMPLETO_ZERO_FLAG_EN)
// Build option: define COMPLETO_ZERO_FLAG_EN to add the zero output.
module subtrator_completo
    import subtrator_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic serial,
`ifdef COMPLETO_ZERO_FLAG_EN
    output logic zero,
`endif
    output logic s,
    output logic cout
);

    if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("subtrator_completo: LATENCY must be 1..%0d", LAT_MAX);
    end

    logic brw_q;
    logic bin;
    logic s0;
    logic c0;

    // A serial=0 cycle always restarts the chain from cin.
    assign bin = serial ? brw_q : cin;
    assign s0  = fs_diff(a, b, bin);
    assign c0  = fs_borrow(a, b, bin);

    always_ff @(posedge clk) begin
        if (rst) brw_q <= 1'b0;
        else     brw_q <= c0;
    end

`ifdef COMPLETO_ZERO_FLAG_EN
    localparam int PW = 3;

    logic z_q;
    logic z0;

    // Running "all difference bits zero" for the current serial word.
    assign z0 = serial ? (z_q & ~s0) : ~s0;

    always_ff @(posedge clk) begin
        if (rst) z_q <= 1'b0;
        else     z_q <= z0;
    end

    logic [PW-1:0] pipe_q;

    fs_pipe #(.W(PW), .DEPTH(LATENCY)) u_pipe (
        .clk (clk),
        .rst (rst),
        .d   ({s0, c0, z0}),
        .q   (pipe_q)
    );

    assign {s, cout, zero} = pipe_q;
`else
    localparam int PW = 2;

    logic [PW-1:0] pipe_q;

    fs_pipe #(.W(PW), .DEPTH(LATENCY)) u_pipe (
        .clk (clk),
        .rst (rst),
        .d   ({s0, c0}),
        .q   (pipe_q)
    );

    assign {s, cout} = pipe_q;
`endif

endmodule

// File: tb/tb_subtrator_completo.sv
module tb_subtrator_completo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, cin = 1'b0, serial = 1'b0;
    logic s1, c1, s3, c3;
    logic z1, z3;

    always #5 clk = ~clk;

`ifdef COMPLETO_ZERO_FLAG_EN
    subtrator_completo #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .serial(serial),
        .zero(z1), .s(s1), .cout(c1));
    subtrator_completo #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .serial(serial),
        .zero(z3), .s(s3), .cout(c3));
    localparam bit HAS_Z = 1'b1;
`else
    subtrator_completo #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .serial(serial),
        .s(s1), .cout(c1));
    subtrator_completo #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .serial(serial),
        .s(s3), .cout(c3));
    assign z1 = 1'b0;
    assign z3 = 1'b0;
    localparam bit HAS_Z = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    // expected {s, cout, zero}
    logic [2:0] q1[$];
    logic [2:0] q3[$];

    logic m_brw = 1'b0;
    logic m_z   = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs at negedge, push expectations, check after posedge.
    task automatic drive(input logic ia, input logic ib, input logic icin,
                         input logic iser, input logic irst);
        int diff;
        logic ebin, es, ec, ez;
        @(negedge clk);
        a = ia; b = ib; cin = icin; serial = iser; rst = irst;
        if (irst) begin
            m_brw = 1'b0;
            m_z   = 1'b0;
            q1.push_back(3'b000);
            q3.delete();
            repeat (3) q3.push_back(3'b000);
        end else begin
            ebin = iser ? m_brw : icin;
            diff = int'(ia) - int'(ib) - int'(ebin);
            es = diff[0];
            ec = (diff < 0);
            ez = iser ? (m_z & ~es) : ~es;
            m_brw = ec;
            m_z   = ez;
            q1.push_back({es, ec, ez & HAS_Z});
            q3.push_back({es, ec, ez & HAS_Z});
        end
        @(posedge clk);
        #1;
        chk("lat1", {5'd0, s1, c1, z1}, {5'd0, q1.pop_front()});
        if (q3.size() >= 3)
            chk("lat3", {5'd0, s3, c3, z3}, {5'd0, q3.pop_front()});
    endtask

    // 4-bit LSB-first serial word; checks assembled difference and final borrow.
    task automatic word(input logic [3:0] wa, input logic [3:0] wb);
        logic [3:0] w;
        logic [3:0] ed;
        for (int i = 0; i < 4; i++) begin
            drive(wa[i], wb[i], 1'b0, (i != 0), 1'b0);
            w[i] = s1;
        end
        ed = wa - wb;
        chk("word", {3'd0, c1, w}, {3'd0, (wa < wb), ed});
        if (HAS_Z)
            chk("zero", {7'd0, z1}, {7'd0, (wa == wb)});
    endtask

    initial begin
        // reset
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("rst_out", {6'd0, s1, c1}, 8'd0);

        // directed, serial=0
        drive(0, 0, 0, 0, 0); chk("d000", {6'd0, s1, c1}, 8'b00);
        drive(0, 1, 1, 0, 0); chk("d011", {6'd0, s1, c1}, 8'b01);
        drive(1, 0, 0, 0, 0); chk("d100", {6'd0, s1, c1}, 8'b10);
        drive(1, 1, 0, 0, 0); chk("d110", {6'd0, s1, c1}, 8'b00);

        // exhaustive, serial=0 (LATENCY=3 checked by the scoreboard)
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            drive(v[2], v[1], v[0], 0, 0);
        end

        // serial words
        word(4'd5, 4'd6);
        word(4'd9, 4'd9);
        word(4'd12, 4'd3);
        word(4'd0, 4'd15);

        // reset mid-word
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 1);
        chk("rst_mid", {5'd0, s1, c1, z1}, 8'd0);
        drive(0, 0, 0, 1, 0);
        chk("rst_clr", {6'd0, s1, c1}, 8'b00);

        // serial restart ignores a pending borrow
        drive(0, 1, 0, 0, 0);
        chk("brw_set", {6'd0, s1, c1}, 8'b11);
        drive(0, 0, 0, 0, 0);
        chk("restart", {6'd0, s1, c1}, 8'b00);

        // random traffic with occasional reset
        for (int k = 0; k < 60; k++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 15) == 0));
        end
        for (int k = 0; k < 6; k++) drive(1'($urandom), 1'($urandom), 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
